// File: rtl/dpa_pkg.sv
// Shared definitions for the dual-path-adder operand stage: op codes and
// the carry-dependency helper.
package dpa_pkg;

    localparam int OP_LEN = 3;

    localparam logic [OP_LEN-1:0] OP_ADD  = 3'd0;
    localparam logic [OP_LEN-1:0] OP_SUB  = 3'd1;
    localparam logic [OP_LEN-1:0] OP_ADC  = 3'd2;
    localparam logic [OP_LEN-1:0] OP_SBB  = 3'd3;
    localparam logic [OP_LEN-1:0] OP_CMP  = 3'd4;
    localparam logic [OP_LEN-1:0] OP_INC  = 3'd5;
    localparam logic [OP_LEN-1:0] OP_DEC  = 3'd6;
    localparam logic [OP_LEN-1:0] OP_PASS = 3'd7;

    // Ops whose carry-in reads c_flag and so must wait for older results.
    function automatic logic is_carry_dep(input logic [OP_LEN-1:0] op);
        return (op == OP_ADC) || (op == OP_SBB);
    endfunction

endpackage

// File: rtl/dpa_operand_stage_if.sv
// Request, adder-side, result-return and status signals of the operand stage.
// The slave modport is the stage itself; master is whoever drives it.
interface dpa_operand_stage_if #(
    parameter int WIDTH = 32
);
    logic                        in_valid;
    logic                        in_ready;
    logic [dpa_pkg::OP_LEN-1:0]  in_op;
    logic [WIDTH-1:0]            in_a;
    logic [WIDTH-1:0]            in_b;

    logic                        out_valid;
    logic                        out_ready;
    logic [WIDTH-1:0]            out_a;
    logic [WIDTH-1:0]            out_b;
    logic                        out_cin;
    logic [dpa_pkg::OP_LEN-1:0]  out_op;

    logic                        res_valid;
    logic                        res_upd;
    logic                        res_cout;

    logic                        c_flag;
    logic [3:0]                  pend_cnt;
    logic                        busy;

    modport slave (
        input  in_valid, in_op, in_a, in_b, out_ready, res_valid, res_upd, res_cout,
        output in_ready, out_valid, out_a, out_b, out_cin, out_op, c_flag, pend_cnt, busy
    );

    modport master (
        output in_valid, in_op, in_a, in_b, out_ready, res_valid, res_upd, res_cout,
        input  in_ready, out_valid, out_a, out_b, out_cin, out_op, c_flag, pend_cnt, busy
    );

endinterface

// File: rtl/dpa_op_decode.sv
// Combinational op decode: turns an op code into adder operands a, b, cin.
module dpa_op_decode
    import dpa_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [OP_LEN-1:0] op_i,
    input  logic [WIDTH-1:0]  a_i,
    input  logic [WIDTH-1:0]  b_i,
    input  logic              c_flag_i,
    output logic [WIDTH-1:0]  a_o,
    output logic [WIDTH-1:0]  b_o,
    output logic              cin_o
);

    assign a_o = a_i;

    always_comb begin
        // NOTE: defaults first so every path assigns and no latch is inferred.
        b_o   = b_i;
        cin_o = 1'b0;
        unique case (op_i)
            OP_ADD:  begin b_o = b_i;        cin_o = 1'b0;     end
            OP_SUB:  begin b_o = ~b_i;       cin_o = 1'b1;     end
            OP_ADC:  begin b_o = b_i;        cin_o = c_flag_i; end
            OP_SBB:  begin b_o = ~b_i;       cin_o = c_flag_i; end
            OP_CMP:  begin b_o = ~b_i;       cin_o = 1'b1;     end
            OP_INC:  begin b_o = '0;         cin_o = 1'b1;     end
            OP_DEC:  begin b_o = '1;         cin_o = 1'b0;     end
            OP_PASS: begin b_o = '0;         cin_o = 1'b0;     end
            default: begin b_o = b_i;        cin_o = 1'b0;     end
        endcase
    end

endmodule

// File: rtl/dpa_operand_stage.sv
// Registered operand-preparation stage in front of the dual-path adder:
// decodes ops, holds the carry flag and counts ops still in flight.
module dpa_operand_stage
    import dpa_pkg::*;
#(
    parameter int WIDTH    = 32,
    parameter int MAX_PEND = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    dpa_operand_stage_if.slave  bus
);

    localparam logic [3:0] MAX_PEND_C = 4'(MAX_PEND);

    logic [WIDTH-1:0]  dec_a;
    logic [WIDTH-1:0]  dec_b;
    logic              dec_cin;

    logic              out_valid_q;
    logic [WIDTH-1:0]  out_a_q;
    logic [WIDTH-1:0]  out_b_q;
    logic              out_cin_q;
    logic [OP_LEN-1:0] out_op_q;
    logic              c_flag_q;
    logic [3:0]        pend_cnt_q;
    logic [3:0]        pend_cnt_d;

    logic              in_ready;
    logic              accept;
    logic              res_take;

    dpa_op_decode #(.WIDTH(WIDTH)) u_decode (
        .op_i     (bus.in_op),
        .a_i      (bus.in_a),
        .b_i      (bus.in_b),
        .c_flag_i (c_flag_q),
        .a_o      (dec_a),
        .b_o      (dec_b),
        .cin_o    (dec_cin)
    );

    // ADC/SBB wait for an empty pipeline so c_flag already holds every older carry.
    assign in_ready = (!out_valid_q || bus.out_ready)
                   && (pend_cnt_q < MAX_PEND_C)
                   && !(is_carry_dep(bus.in_op) && (pend_cnt_q != 4'd0));
    assign accept   = bus.in_valid && in_ready;
    assign res_take = bus.res_valid && (pend_cnt_q != 4'd0);

    always_comb begin
        pend_cnt_d = pend_cnt_q;
        unique case ({accept, res_take})
            2'b10:   pend_cnt_d = pend_cnt_q + 4'd1;
            2'b01:   pend_cnt_d = pend_cnt_q - 4'd1;
            default: pend_cnt_d = pend_cnt_q;
        endcase
    end

    // NOTE: sequential state is written only with non-blocking assignments.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_a_q     <= '0;
            out_b_q     <= '0;
            out_cin_q   <= 1'b0;
            out_op_q    <= '0;
            c_flag_q    <= 1'b0;
            pend_cnt_q  <= 4'd0;
        end else begin
            if (accept) begin
                out_valid_q <= 1'b1;
                out_a_q     <= dec_a;
                out_b_q     <= dec_b;
                out_cin_q   <= dec_cin;
                out_op_q    <= bus.in_op;
            end else if (bus.out_ready) begin
                out_valid_q <= 1'b0;
            end
            if (bus.res_valid && bus.res_upd) begin
                c_flag_q <= bus.res_cout;
            end
            pend_cnt_q <= pend_cnt_d;
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid_q;
    assign bus.out_a     = out_a_q;
    assign bus.out_b     = out_b_q;
    assign bus.out_cin   = out_cin_q;
    assign bus.out_op    = out_op_q;
    assign bus.c_flag    = c_flag_q;
    assign bus.pend_cnt  = pend_cnt_q;
    assign bus.busy      = (pend_cnt_q != 4'd0);

endmodule

// File: tb/tb_dpa_operand_stage.sv
// Scoreboard bench for dpa_operand_stage: directed ops push expected operands,
// a monitor pops and compares on every output transfer.
module tb_dpa_operand_stage;
    import dpa_pkg::*;

    typedef struct {
        logic [31:0]       a;
        logic [31:0]       b;
        logic              cin;
        logic [OP_LEN-1:0] op;
    } exp_t;

    logic clk;
    logic rst_n;
    int   errors = 0;
    int   checks = 0;
    exp_t sb_q[$];

    dpa_operand_stage_if #(.WIDTH(32)) bus ();

    dpa_operand_stage #(.WIDTH(32), .MAX_PEND(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: every transfer to the adder is compared against the oldest expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n && bus.out_valid && bus.out_ready) begin
                if (sb_q.size() == 0) begin
                    check("sb_unexpected_out", 32'd1, 32'd0);
                end else begin
                    e = sb_q.pop_front();
                    check("sb_out_a",   bus.out_a, e.a);
                    check("sb_out_b",   bus.out_b, e.b);
                    check("sb_out_cin", {31'd0, bus.out_cin}, {31'd0, e.cin});
                    check("sb_out_op",  {29'd0, bus.out_op},  {29'd0, e.op});
                end
            end
        end
    end

    // Present one op, wait (bounded) for acceptance, push its expectation.
    task automatic send(input logic [OP_LEN-1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] eb, input logic ecin);
        int n = 0;
        exp_t e;
        bus.in_valid = 1'b1;
        bus.in_op    = op;
        bus.in_a     = a;
        bus.in_b     = b;
        @(negedge clk);
        while (!bus.in_ready && n < 40) begin
            n++;
            @(negedge clk);
        end
        if (!bus.in_ready) begin
            check("accept_timeout", 32'd0, 32'd1);
        end else begin
            e.a = a; e.b = eb; e.cin = ecin; e.op = op;
            sb_q.push_back(e);
        end
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic ret(input logic upd, input logic cout);
        bus.res_valid = 1'b1;
        bus.res_upd   = upd;
        bus.res_cout  = cout;
        @(posedge clk);
        #1;
        bus.res_valid = 1'b0;
        bus.res_upd   = 1'b0;
        bus.res_cout  = 1'b0;
    endtask

    initial begin
        logic [31:0] sum;
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_op     = OP_ADD;
        bus.in_a      = '0;
        bus.in_b      = '0;
        bus.out_ready = 1'b1;
        bus.res_valid = 1'b0;
        bus.res_upd   = 1'b0;
        bus.res_cout  = 1'b0;
        #12;
        check("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
        check("rst_pend_cnt",  {28'd0, bus.pend_cnt},  32'd0);
        check("rst_c_flag",    {31'd0, bus.c_flag},    32'd0);
        check("rst_out_a",     bus.out_a, 32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Plain ADD, one-cycle latency.
        send(OP_ADD, 32'd5, 32'd3, 32'd3, 1'b0);
        check("add_out_valid", {31'd0, bus.out_valid}, 32'd1);
        check("add_pend_cnt",  {28'd0, bus.pend_cnt},  32'd1);
        check("add_busy",      {31'd0, bus.busy},      32'd1);
        ret(1'b0, 1'b0);
        check("add_ret_pend",  {28'd0, bus.pend_cnt},  32'd0);
        check("add_drained",   {31'd0, bus.out_valid}, 32'd0);

        // SUB: inverted b plus cin gives the difference.
        send(OP_SUB, 32'd10, 32'd3, 32'hFFFF_FFFC, 1'b1);
        sum = bus.out_a + bus.out_b + {31'd0, bus.out_cin};
        check("sub_sum", sum, 32'd7);
        ret(1'b1, 1'b1);
        check("sub_c_flag", {31'd0, bus.c_flag}, 32'd1);
        send(OP_PASS, 32'h5A5A_0000, 32'h1234, 32'd0, 1'b0);
        ret(1'b1, 1'b0);
        check("pass_c_flag", {31'd0, bus.c_flag}, 32'd0);

        // ADC behind an outstanding ADD must wait for its carry.
        send(OP_ADD, 32'hFFFF_FFFF, 32'd1, 32'd1, 1'b0);
        bus.in_valid = 1'b1;
        bus.in_op    = OP_ADC;
        bus.in_a     = 32'd7;
        bus.in_b     = 32'd8;
        repeat (2) begin
            @(negedge clk);
            check("adc_blocked", {31'd0, bus.in_ready}, 32'd0);
        end
        @(posedge clk);
        #1;
        ret(1'b1, 1'b1);
        check("adc_c_flag_set", {31'd0, bus.c_flag}, 32'd1);
        send(OP_ADC, 32'd7, 32'd8, 32'd8, 1'b1);
        check("adc_out_cin", {31'd0, bus.out_cin}, 32'd1);
        ret(1'b1, 1'b0);

        // SBB with clear carry, then DEC.
        send(OP_SBB, 32'd20, 32'd4, 32'hFFFF_FFFB, 1'b0);
        ret(1'b0, 1'b0);
        send(OP_DEC, 32'd4, 32'h55, 32'hFFFF_FFFF, 1'b0);
        ret(1'b0, 1'b0);

        // Backpressure: output held, no accept, then drain plus accept on one edge.
        bus.out_ready = 1'b0;
        send(OP_ADD, 32'h11, 32'h22, 32'h22, 1'b0);
        bus.in_valid = 1'b1;
        bus.in_op    = OP_INC;
        bus.in_a     = 32'h33;
        bus.in_b     = 32'h99;
        repeat (3) begin
            @(negedge clk);
            check("stall_out_a",    bus.out_a, 32'h11);
            check("stall_out_b",    bus.out_b, 32'h22);
            check("stall_in_ready", {31'd0, bus.in_ready}, 32'd0);
        end
        @(posedge clk);
        #1;
        bus.out_ready = 1'b1;
        send(OP_INC, 32'h33, 32'h99, 32'd0, 1'b1);
        check("drain_accept_pend", {28'd0, bus.pend_cnt}, 32'd2);
        ret(1'b0, 1'b0);
        ret(1'b0, 1'b0);

        // Fill to MAX_PEND, then release one slot.
        for (int i = 1; i <= 4; i++) send(OP_ADD, 32'(i), 32'h10, 32'h10, 1'b0);
        check("full_pend", {28'd0, bus.pend_cnt}, 32'd4);
        bus.in_valid = 1'b1;
        bus.in_op    = OP_CMP;
        bus.in_a     = 32'd9;
        bus.in_b     = 32'd2;
        @(negedge clk);
        check("full_in_ready", {31'd0, bus.in_ready}, 32'd0);
        @(posedge clk);
        #1;
        ret(1'b0, 1'b0);
        check("full_release_pend", {28'd0, bus.pend_cnt}, 32'd3);
        bus.res_valid = 1'b1;
        send(OP_CMP, 32'd9, 32'd2, 32'hFFFF_FFFD, 1'b1);
        bus.res_valid = 1'b0;
        check("acc_and_ret_pend", {28'd0, bus.pend_cnt}, 32'd3);
        repeat (3) ret(1'b0, 1'b0);
        check("empty_busy", {31'd0, bus.busy}, 32'd0);

        // Asynchronous reset in the middle of a stall.
        send(OP_ADD, 32'hFFFF_FFFF, 32'd1, 32'd1, 1'b0);
        ret(1'b1, 1'b1);
        send(OP_ADD, 32'd1, 32'd1, 32'd1, 1'b0);
        send(OP_ADD, 32'd2, 32'd2, 32'd2, 1'b0);
        bus.out_ready = 1'b0;
        check("pre_rst_valid", {31'd0, bus.out_valid}, 32'd1);
        check("pre_rst_pend",  {28'd0, bus.pend_cnt},  32'd2);
        check("pre_rst_cflag", {31'd0, bus.c_flag},    32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        sb_q.delete();
        check("async_rst_valid", {31'd0, bus.out_valid}, 32'd0);
        check("async_rst_pend",  {28'd0, bus.pend_cnt},  32'd0);
        check("async_rst_cflag", {31'd0, bus.c_flag},    32'd0);
        #3;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b1;
        ret(1'b0, 1'b0);
        check("stray_res_pend", {28'd0, bus.pend_cnt}, 32'd0);
        send(OP_PASS, 32'h77, 32'h88, 32'd0, 1'b0);
        ret(1'b0, 1'b0);

        repeat (3) @(posedge clk);
        check("sb_empty", 32'(sb_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
